// File: rtl/noc2_valrdy_pkt_arbiter.sv
// Packet-atomic round-robin arbiter for the shared NoC2 val/rdy request
// channel feeding the NoC-to-AXI4 bridge. Header flits carry a body-length
// field; once a header is granted, the owning port keeps the channel until
// its last body flit is accepted. The output is a single register stage
// with full throughput, and out_src tags each flit with its source port.
module noc2_valrdy_pkt_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_LSB    = 22,
    parameter int LEN_WIDTH  = 8,
    localparam int SRC_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_val,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dat,
    output logic [NUM_PORTS-1:0]            in_rdy,
    output logic                            out_val,
    output logic [DATA_WIDTH-1:0]           out_dat,
    output logic [SRC_W-1:0]                out_src,
    input  logic                            out_rdy,
    output logic                            busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,  // next accepted flit is a header
        ST_BODY = 1'b1   // owner port is streaming body flits
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [SRC_W-1:0]       owner_q, owner_d;
    logic [SRC_W-1:0]       last_grant_q, last_grant_d;
    logic                   out_val_q, out_val_d;
    logic [DATA_WIDTH-1:0]  out_dat_q, out_dat_d;
    logic [SRC_W-1:0]       out_src_q, out_src_d;

    logic                   load;
    logic                   sel_found;
    logic [SRC_W-1:0]       sel;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  sel_dat;
    logic [LEN_WIDTH-1:0]   hdr_len;

    // The output register can take a new flit when it is empty or draining.
    assign load = ~out_val_q | out_rdy;

    // Port selection: the owner while a body is in progress, otherwise the
    // first valid port scanning upward from the one after the last grant.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel       = owner_q;
        sel_found = 1'b0;
        if (state_q == ST_BODY) begin
            sel       = owner_q;
            sel_found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                if (!sel_found && in_val[(int'(last_grant_q) + k) % NUM_PORTS]) begin
                    sel_found = 1'b1;
                    sel       = SRC_W'((int'(last_grant_q) + k) % NUM_PORTS);
                end
            end
        end
    end

    assign sel_dat = in_dat[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign hdr_len = sel_dat[LEN_LSB +: LEN_WIDTH];
    assign accept  = load & sel_found & in_val[sel];

    // Ready goes only to the selected port, and only when the output can load.
    always_comb begin
        in_rdy = '0;
        if (load && sel_found) begin
            in_rdy[sel] = 1'b1;
        end
    end

    // Next-state and output-register logic for the packet FSM.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        out_val_d    = out_val_q;
        out_dat_d    = out_dat_q;
        out_src_d    = out_src_q;

        if (load) begin
            out_val_d = accept;
            if (accept) begin
                out_dat_d = sel_dat;
                out_src_d = sel;
            end
        end

        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Round-robin pointer moves only on header acceptance.
                    last_grant_d = sel;
                    if (hdr_len != '0) begin
                        rem_d   = hdr_len;
                        owner_d = sel;
                        state_d = ST_BODY;
                    end
                end
                ST_BODY: begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            // NOTE: all registers are reset, including out_dat, because their
            // reset values are visible on the ports; a packet in flight is dropped.
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            owner_q      <= '0;
            last_grant_q <= SRC_W'(NUM_PORTS - 1);
            out_val_q    <= 1'b0;
            out_dat_q    <= '0;
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            out_val_q    <= out_val_d;
            out_dat_q    <= out_dat_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out_val = out_val_q;
    assign out_dat = out_dat_q;
    assign out_src = out_src_q;
    assign busy    = (state_q == ST_BODY);

endmodule
